// File: rtl/cpu_core_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: state encoding, opcodes and
// instruction-format decode helpers.
// Optional feature macro: CPU_CORE_LOGIC_OPS_EN adds the AND/OR/XOR opcodes.
package cpu_core_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle = 4'd0;
  localparam state_t StF1   = 4'd1;
  localparam state_t StD1   = 4'd2;
  localparam state_t StF2   = 4'd3;
  localparam state_t StD2   = 4'd4;
  localparam state_t StM1   = 4'd5;
  localparam state_t StM2   = 4'd6;
  localparam state_t StEx   = 4'd7;
  localparam state_t StHalt = 4'd8;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OpNop = 8'h00;
  localparam opcode_t OpLda = 8'h01;
  localparam opcode_t OpAdd = 8'h02;
  localparam opcode_t OpSub = 8'h03;
  localparam opcode_t OpSta = 8'h04;
  localparam opcode_t OpLdi = 8'h05;
  localparam opcode_t OpJmp = 8'h06;
  localparam opcode_t OpJc  = 8'h07;
  localparam opcode_t OpJz  = 8'h08;
  localparam opcode_t OpOut = 8'h09;
  localparam opcode_t OpAnd = 8'h0A;
  localparam opcode_t OpOr  = 8'h0B;
  localparam opcode_t OpXor = 8'h0C;
  localparam opcode_t OpHlt = 8'h0F;

  // Instruction carries an operand byte after the opcode.
  function automatic logic is_two_byte(input opcode_t op);
    logic r;
    r = (op >= OpLda) && (op <= OpJz);
`ifdef CPU_CORE_LOGIC_OPS_EN
    if ((op == OpAnd) || (op == OpOr) || (op == OpXor)) r = 1'b1;
`endif
    return r;
  endfunction

  // Operand is an address whose contents must be fetched into B.
  function automatic logic needs_mem_read(input opcode_t op);
    logic r;
    r = (op == OpLda) || (op == OpAdd) || (op == OpSub);
`ifdef CPU_CORE_LOGIC_OPS_EN
    if ((op == OpAnd) || (op == OpOr) || (op == OpXor)) r = 1'b1;
`endif
    return r;
  endfunction

  // Instruction updates A, C and Z from the ALU.
  function automatic logic writes_acc(input opcode_t op);
    return needs_mem_read(op) || (op == OpLdi);
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core. LDA/LDI pass B straight through with carry
// preserved; ADD/SUB produce carry from the extra sum bit.
// Optional feature macro: CPU_CORE_LOGIC_OPS_EN adds AND/OR/XOR.
module cpu_core_alu
  import cpu_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  opcode_t               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  c_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  c_o,
  output logic                  z_o
);

  logic [DATA_WIDTH:0] sum;

  // Select result and carry by opcode; zero flag follows the result.
  always_comb begin
    sum   = '0;
    res_o = b_i;
    c_o   = c_i;
    case (op_i)
      OpAdd: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res_o = sum[DATA_WIDTH-1:0];
        c_o   = sum[DATA_WIDTH];
      end
      OpSub: begin
        // Carry set means no borrow.
        sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
        res_o = sum[DATA_WIDTH-1:0];
        c_o   = sum[DATA_WIDTH];
      end
`ifdef CPU_CORE_LOGIC_OPS_EN
      OpAnd: begin
        res_o = a_i & b_i;
        c_o   = 1'b0;
      end
      OpOr: begin
        res_o = a_i | b_i;
        c_o   = 1'b0;
      end
      OpXor: begin
        res_o = a_i ^ b_i;
        c_o   = 1'b0;
      end
`endif
      default: ;
    endcase
    z_o = (res_o == '0);
  end

endmodule

// File: rtl/cpu_core.sv
// 8-bit accumulator CPU on the CPU-side port of the shared program/data memory.
// Sequence: F1/D1 fetch opcode, F2/D2 fetch operand, M1/M2 read memory operand,
// EX execute. Dropping cpu_run_i returns to IDLE and clears PC/A/B/C/Z.
// Optional feature macro: CPU_CORE_LOGIC_OPS_EN adds the AND/OR/XOR opcodes.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int unsigned                 MEM_ADDR_WIDTH = 8,
  parameter int unsigned                 MEM_DATA_WIDTH = 8,
  parameter logic [MEM_ADDR_WIDTH-1:0]   RESET_PC       = '0
) (
  input  logic                      clock_i,
  input  logic                      rst_n,
  input  logic                      cpu_run_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
  output logic                      mem_rnw_o,
  output logic [MEM_DATA_WIDTH-1:0] out_data_o,
  output logic                      out_valid_o,
  output logic                      halted_o,
  output logic [MEM_ADDR_WIDTH-1:0] pc_dbg_o
);

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_DATA_WIDTH-1:0] a_q, a_d;
  logic [MEM_DATA_WIDTH-1:0] b_q, b_d;
  logic [MEM_DATA_WIDTH-1:0] ir_q, ir_d;
  logic [MEM_DATA_WIDTH-1:0] opr_q, opr_d;
  logic                      c_q, c_d;
  logic                      z_q, z_d;
  logic [MEM_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;

  opcode_t                   ir_op;
  opcode_t                   rdata_op;
  logic [MEM_DATA_WIDTH-1:0] alu_b;
  logic [MEM_DATA_WIDTH-1:0] alu_res;
  logic                      alu_c;
  logic                      alu_z;

  assign ir_op    = opcode_t'(ir_q);
  assign rdata_op = opcode_t'(mem_rdata_i);

  // LDI takes its immediate operand; all other ALU ops use the fetched B.
  assign alu_b = (ir_op == OpLdi) ? opr_q : b_q;

  cpu_core_alu #(
    .DATA_WIDTH (MEM_DATA_WIDTH)
  ) u_alu (
    .op_i  (ir_op),
    .a_i   (a_q),
    .b_i   (alu_b),
    .c_i   (c_q),
    .res_o (alu_res),
    .c_o   (alu_c),
    .z_o   (alu_z)
  );

  // Next-state logic for the fetch/decode/execute sequence and architectural state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    opr_d       = opr_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      StIdle: if (cpu_run_i) state_d = StF1;
      StF1:   state_d = StD1;
      StD1: begin
        ir_d    = mem_rdata_i;
        pc_d    = pc_q + 1'b1;
        state_d = is_two_byte(rdata_op) ? StF2 : StEx;
      end
      StF2:   state_d = StD2;
      StD2: begin
        opr_d   = mem_rdata_i;
        pc_d    = pc_q + 1'b1;
        state_d = needs_mem_read(ir_op) ? StM1 : StEx;
      end
      StM1:   state_d = StM2;
      StM2: begin
        b_d     = mem_rdata_i;
        state_d = StEx;
      end
      StEx: begin
        if (writes_acc(ir_op)) begin
          a_d = alu_res;
          c_d = alu_c;
          z_d = alu_z;
        end
        case (ir_op)
          OpJmp: pc_d = MEM_ADDR_WIDTH'(opr_q);
          OpJc:  if (c_q) pc_d = MEM_ADDR_WIDTH'(opr_q);
          OpJz:  if (z_q) pc_d = MEM_ADDR_WIDTH'(opr_q);
          OpOut: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
          end
          default: ;
        endcase
        state_d = (ir_op == OpHlt) ? StHalt : StF1;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // Run dropped: abandon the instruction; an STA write driven this cycle still lands.
    if (!cpu_run_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      pc_d        = RESET_PC;
      a_d         = '0;
      b_d         = '0;
      c_d         = 1'b0;
      z_d         = 1'b0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end
  end

  // State and register update with asynchronous active-low reset.
  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      opr_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_q        <= ir_d;
      opr_q       <= opr_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Memory port driven combinationally from the current state.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_rnw_o   = 1'b1;
    case (state_q)
      StF1, StF2: mem_addr_o = pc_q;
      StM1:       mem_addr_o = MEM_ADDR_WIDTH'(opr_q);
      StEx: begin
        if (ir_op == OpSta) begin
          mem_addr_o  = MEM_ADDR_WIDTH'(opr_q);
          mem_wdata_o = a_q;
          mem_rnw_o   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = (state_q == StHalt);
  assign pc_dbg_o    = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: an instruction-level reference model predicts
// output pulses and memory writes (with their cycle) into a scoreboard queue; a
// monitor pops and compares whenever the core presents one.
module tb_cpu_core;

  logic       clk;
  logic       rst_n;
  logic       cpu_run;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rnw;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [7:0] pc_dbg;

  cpu_core #(
    .MEM_ADDR_WIDTH (8),
    .MEM_DATA_WIDTH (8),
    .RESET_PC       (8'h00)
  ) dut (
    .clock_i     (clk),
    .rst_n       (rst_n),
    .cpu_run_i   (cpu_run),
    .mem_rdata_i (mem_rdata),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rnw_o   (mem_rnw),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .halted_o    (halted),
    .pc_dbg_o    (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory: registered read, one-cycle write on the CPU port.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (!mem_rnw) mem[mem_addr] = mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state.
  logic [7:0]  rmem [256];
  logic [7:0]  r_pc, r_a, r_out;
  bit          r_c, r_z, r_halt;
  int unsigned r_t;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && out_valid) begin
      n_checks++;
      if (exp_q.size() == 0 || exp_q[0].is_wr) begin
        n_fail++;
        $display("FAIL out_pulse: unexpected out_valid data %0h at cycle %0d", out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out_pulse: got data %0h cycle %0d expected data %0h cycle %0d",
                   out_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (rst_n && !mem_rnw) begin
      n_checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
        n_fail++;
        $display("FAIL mem_write: unexpected write %0h<=%0h at cycle %0d", mem_addr, mem_wdata,
                 cyc);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL mem_write: got %0h<=%0h cycle %0d expected %0h<=%0h cycle %0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic bit two_byte(input logic [7:0] op);
    if (op >= 8'h01 && op <= 8'h08) return 1'b1;
`ifdef CPU_CORE_LOGIC_OPS_EN
    if (op >= 8'h0A && op <= 8'h0C) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Execute one instruction at cycle r_t (its first fetch cycle) and predict events.
  task automatic iss_step();
    logic [7:0]  op, opr, b;
    int unsigned cpi;
    int          s;
    op  = rmem[r_pc];
    r_pc = r_pc + 8'd1;
    cpi = 3;
    opr = 8'h00;
    if (two_byte(op)) begin
      opr  = rmem[r_pc];
      r_pc = r_pc + 8'd1;
      cpi  = 5;
    end
    b = rmem[opr];
    case (op)
      8'h01: begin cpi = 7; r_a = b; r_z = (r_a == 0); end
      8'h02: begin
        cpi = 7; s = int'(r_a) + int'(b);
        r_c = (s > 255); r_a = 8'(s); r_z = (r_a == 0);
      end
      8'h03: begin
        cpi = 7; r_c = (r_a >= b); r_a = r_a - b; r_z = (r_a == 0);
      end
      8'h04: begin
        exp_q.push_back('{is_wr: 1'b1, addr: opr, data: r_a, cyc: r_t + 4});
        rmem[opr] = r_a;
      end
      8'h05: begin r_a = opr; r_z = (r_a == 0); end
      8'h06: r_pc = opr;
      8'h07: if (r_c) r_pc = opr;
      8'h08: if (r_z) r_pc = opr;
      8'h09: begin
        r_out = r_a;
        exp_q.push_back('{is_wr: 1'b0, addr: 8'h00, data: r_a, cyc: r_t + 3});
      end
`ifdef CPU_CORE_LOGIC_OPS_EN
      8'h0A: begin cpi = 7; r_a = r_a & b; r_c = 1'b0; r_z = (r_a == 0); end
      8'h0B: begin cpi = 7; r_a = r_a | b; r_c = 1'b0; r_z = (r_a == 0); end
      8'h0C: begin cpi = 7; r_a = r_a ^ b; r_c = 1'b0; r_z = (r_a == 0); end
`endif
      8'h0F: r_halt = 1'b1;
      default: ;
    endcase
    r_t += cpi;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Raise cpu_run from IDLE; model starts from a cleared core at PC 0.
  task automatic start_run();
    @(negedge clk);
    for (int i = 0; i < 256; i++) rmem[i] = mem[i];
    r_pc = 8'h00; r_a = 8'h00; r_c = 1'b0; r_z = 1'b0; r_halt = 1'b0;
    r_t = cyc + 1;
    cpu_run = 1'b1;
  endtask

  // Run to HLT or to max_instr instructions, then drop cpu_run and check the return.
  task automatic run_to_end(input string nm, input int max_instr);
    int          n;
    int unsigned lim;
    n = 0;
    while (!r_halt && n < max_instr) begin
      iss_step();
      n++;
    end
    if (r_halt) begin
      lim = r_t + 10;
      while (!halted && cyc < lim) @(negedge clk);
      chk({nm, " halted"}, 32'(halted), 1);
      chk({nm, " halt_cycle"}, cyc, r_t);
      chk({nm, " halt_pc"}, 32'(pc_dbg), 32'(r_pc));
    end else begin
      while (cyc < r_t) @(negedge clk);
      chk({nm, " pc"}, 32'(pc_dbg), 32'(r_pc));
    end
    chk({nm, " out_data"}, 32'(out_data), 32'(r_out));
    cpu_run = 1'b0;
    @(negedge clk);
    chk({nm, " idle_pc"}, 32'(pc_dbg), 0);
    chk({nm, " idle_halted"}, 32'(halted), 0);
    chk({nm, " events_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t_add;
    rst_n   = 1'b0;
    cpu_run = 1'b0;
    r_out   = 8'h00;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    chk("rst mem_rnw", 32'(mem_rnw), 1);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst pc", 32'(pc_dbg), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle pc", 32'(pc_dbg), 0);
    chk("idle rnw", 32'(mem_rnw), 1);

    // LDI 05; OUT; HLT
    clear_mem();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h05; mem[8'h02] = 8'h09; mem[8'h03] = 8'h0F;
    start_run();
    run_to_end("ldi_out_hlt", 50);

    // LDI FF; ADD [80]; JC 20; at 20: JZ 24; 24: OUT; HLT
    clear_mem();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'hFF; mem[8'h02] = 8'h02; mem[8'h03] = 8'h80;
    mem[8'h04] = 8'h07; mem[8'h05] = 8'h20; mem[8'h06] = 8'h0F; mem[8'h80] = 8'h01;
    mem[8'h20] = 8'h08; mem[8'h21] = 8'h24; mem[8'h22] = 8'h0F;
    mem[8'h24] = 8'h09; mem[8'h25] = 8'h0F;
    start_run();
    run_to_end("add_carry", 50);

    // LDI 3C; STA 90; LDA 90; OUT; HLT
    clear_mem();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h04; mem[8'h03] = 8'h90;
    mem[8'h04] = 8'h01; mem[8'h05] = 8'h90; mem[8'h06] = 8'h09; mem[8'h07] = 8'h0F;
    start_run();
    run_to_end("sta_lda", 50);
    chk("sta mem90", 32'(mem[8'h90]), 32'h3C);

    // LDI 03; SUB [81]; JZ 20; JC 20; OUT; HLT
    clear_mem();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h03; mem[8'h02] = 8'h03; mem[8'h03] = 8'h81;
    mem[8'h04] = 8'h08; mem[8'h05] = 8'h20; mem[8'h06] = 8'h07; mem[8'h07] = 8'h20;
    mem[8'h08] = 8'h09; mem[8'h09] = 8'h0F; mem[8'h81] = 8'h04; mem[8'h20] = 8'h0F;
    start_run();
    run_to_end("sub_borrow", 50);

    // PC wrap: NOP(AA); OUT; JC 10; LDI FF; ADD [80]; JMP FF; FF: LDI (operand at 00)
    clear_mem();
    mem[8'h00] = 8'hAA; mem[8'h01] = 8'h09; mem[8'h02] = 8'h07; mem[8'h03] = 8'h10;
    mem[8'h04] = 8'h05; mem[8'h05] = 8'hFF; mem[8'h06] = 8'h02; mem[8'h07] = 8'h80;
    mem[8'h08] = 8'h06; mem[8'h09] = 8'hFF; mem[8'hFF] = 8'h05; mem[8'h80] = 8'h01;
    mem[8'h10] = 8'h0F;
    start_run();
    run_to_end("pc_wrap", 50);

    // Abort in M2 of ADD, then restart from 0 with A cleared.
    clear_mem();
    mem[8'h00] = 8'h09; mem[8'h01] = 8'h05; mem[8'h02] = 8'h07; mem[8'h03] = 8'h02;
    mem[8'h04] = 8'h80; mem[8'h05] = 8'h09; mem[8'h06] = 8'h0F; mem[8'h80] = 8'h01;
    start_run();
    iss_step();
    iss_step();
    t_add = r_t;
    while (cyc < t_add + 5) @(negedge clk);
    cpu_run = 1'b0;
    @(negedge clk);
    chk("abort pc", 32'(pc_dbg), 0);
    chk("abort halted", 32'(halted), 0);
    chk("abort rnw", 32'(mem_rnw), 1);
    chk("abort events_left", 32'(exp_q.size()), 0);
    exp_q.delete();
    start_run();
    run_to_end("abort_restart", 50);

    // Random programs against the reference model.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      start_run();
      run_to_end($sformatf("rand%0d", p), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- 8-bit accumulator CPU; consumes the CPU-side port of the shared program/data memory.
- The SPI ROM controller loads that memory through the other port.
- Executes a fixed two-format instruction set: fetch, decode, operand fetch, execute, with optional write-back.
- Held idle while `cpu_run` is low, so software can be loaded over SPI first; runs from `RESET_PC` once `cpu_run` rises.

Parameters:
- MEM_ADDR_WIDTH, 8, width of the memory address and PC.
- MEM_DATA_WIDTH, 8, width of memory data, A, B, IR and the operand register.
- RESET_PC, 0, PC value after reset or after `cpu_run` drops.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cpu_run  in  1  high = execute; low = synchronous return to IDLE.
- mem_rdata  in  MEM_DATA_WIDTH  memory read data; valid the cycle after the address is presented.
- mem_addr  out  MEM_ADDR_WIDTH  memory address.
- mem_wdata  out  MEM_DATA_WIDTH  write data (A during STA, else 0).
- mem_rnw  out  1  1 = read, 0 = write; write lasts exactly one cycle.
- out_data  out  MEM_DATA_WIDTH  output register, loaded by OUT.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- halted  out  1  high while in HALT.
- pc_dbg  out  MEM_ADDR_WIDTH  current PC.

Behaviour:
- Reset values:
  - state = IDLE; PC = RESET_PC; A, B, IR, OPR = 0; C, Z = 0.
  - mem_addr = 0, mem_wdata = 0, mem_rnw = 1.
  - out_data = 0, out_valid = 0, halted = 0.
- Memory outputs are combinational from state and registers. All registers update on the rising edge of `clock`.
- States and transitions:
  - IDLE: drives addr 0, rnw 1. Goes to F1 when cpu_run = 1.
  - F1: addr = PC. Next state D1.
  - D1: IR <= mem_rdata; PC <= PC+1.
    - Two-byte opcode -> F2.
    - One-byte opcode -> EX.
  - F2: addr = PC. Next state D2.
  - D2: OPR <= mem_rdata; PC <= PC+1.
    - LDA/ADD/SUB/logic ops -> M1.
    - Otherwise -> EX.
  - M1: addr = OPR. Next state M2.
  - M2: B <= mem_rdata. Next state EX.
  - EX: execute the instruction.
    - HLT -> HALT.
    - Otherwise -> F1.
  - HALT: halted = 1; stays until cpu_run = 0.
- Cycles per instruction:
  - One-byte: 3.
  - LDI / JMP / JC / JZ / STA: 5.
  - LDA / ADD / SUB / logic ops: 7.
- Opcodes (IR value):
  - 00 NOP.
  - 01 LDA a: A = B; Z updated.
  - 02 ADD a: {C,A} = A+B; Z updated.
  - 03 SUB a: {C,A} = A + ~B + 1 (C = 1 means no borrow); Z updated.
  - 04 STA a: EX drives addr = OPR, wdata = A, rnw = 0.
  - 05 LDI i: A = OPR; Z updated.
  - 06 JMP a: PC = OPR.
  - 07 JC a: PC = OPR if C.
  - 08 JZ a: PC = OPR if Z.
  - 09 OUT: out_data = A; out_valid pulses in the cycle after EX.
  - 0F HLT.
  - 01-08 are two-byte; all others are one-byte.
- Undefined opcodes execute as one-byte NOP. Flags are unchanged by NOP, STA, jumps and OUT.
- Arithmetic is modulo 2^MEM_DATA_WIDTH; carry is bit MEM_DATA_WIDTH of the 9-bit sum.
- PC wraps 0xFF -> 0x00. A two-byte instruction at 0xFF fetches its operand from 0x00.
- cpu_run falling in any non-IDLE state:
  - Next edge: IDLE, PC = RESET_PC, A/B/C/Z cleared.
  - out_data is held.
  - A STA write presented in that cycle still completes.
- cpu_run high in IDLE begins fetching at RESET_PC on the next edge.

Optional Feature:
- Macro: CPU_CORE_LOGIC_OPS_EN.
- Defined: adds two-byte opcodes 0A AND a, 0B OR a, 0C XOR a.
  - Each takes the M1/M2 path.
  - A = A op B; Z updated; C cleared.
- Undefined: 0A-0C decode as one-byte NOP; no extra logic is built.

Decomposition:
- Package cpu_core_pkg holds:
  - state enum;
  - opcode localparams;
  - is_two_byte and needs_mem_read decode functions.
- One sub-module, cpu_core_alu: combinational op, A, B -> result, C, Z.
- The FSM, PC and registers stay in cpu_core.

Test Plan:
- Sequencing from reset: memory loaded via backdoor, cpu_run = 1.
  - Program LDI 05; OUT; HLT -> out_data = 0x05 with one out_valid pulse, then halted = 1.
  - Instruction cycle counts are 5 / 3 / 3.
- Carry flag on ADD: LDI FF; ADD [80] with mem[80] = 01; JC 20.
  - A = 00, C = 1, Z = 1; PC = 0x20 after the jump.
- Store and write pulse: LDI 3C; STA 90; LDA 90; OUT.
  - mem[90] = 3C; mem_rnw low for exactly one cycle; out_data = 3C.
- Borrow and zero on SUB: LDI 03; SUB [81] with mem[81] = 04.
  - A = FF, C = 0, Z = 0.
  - JZ not taken; JC not taken.
- PC wrap: LDI at 0xFF with mem[00] = AA.
  - A = AA; next fetch from 0x01.
- cpu_run abort: cpu_run dropped during M2 of ADD.
  - Next cycle IDLE, PC = RESET_PC, no write, halted = 0.
  - Re-assert cpu_run -> fetch from 0x00.
